// File: rtl/layer_mvm_par_pkg.sv
// Shared types and arithmetic helpers for the fully-connected layer engine.
// Helpers work on a MAXW-bit container so one definition serves every T/N.
package layer_pkg;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  localparam int unsigned MAXW = 64;

  // Exact accumulator width: full 2T-bit products summed N times plus a bias.
  function automatic int unsigned acc_w(input int unsigned t, input int unsigned n);
    return 2 * t + $clog2(n + 1);
  endfunction

  function automatic logic signed [MAXW-1:0] sat_to_t(input logic signed [MAXW-1:0] v,
                                                      input int unsigned             t);
    logic signed [MAXW-1:0] hi;
    logic signed [MAXW-1:0] lo;
    hi = signed'((64'd1 << (t - 1)) - 64'd1);
    lo = ~hi;
    if (v > hi)
      return hi;
    else if (v < lo)
      return lo;
    else
      return v;
  endfunction

  function automatic logic signed [MAXW-1:0] relu(input logic signed [MAXW-1:0] v);
    return v[MAXW-1] ? '0 : v;
  endfunction

endpackage

// File: rtl/layer_mvm_par_if.sv
// Input and output valid/ready streams of the layer engine.
// slave is the engine side, master is the upstream/downstream side.
interface layer_mvm_par_if #(
  parameter int unsigned T = 16
) ();

  logic                s_valid;
  logic                s_ready;
  logic signed [T-1:0] data_in;
  logic                m_valid;
  logic                m_ready;
  logic signed [T-1:0] data_out;

  modport slave (
    input  s_valid,
    input  data_in,
    input  m_ready,
    output s_ready,
    output m_valid,
    output data_out
  );

  modport master (
    output s_valid,
    output data_in,
    output m_ready,
    input  s_ready,
    input  m_valid,
    input  data_out
  );

endinterface

// File: rtl/layer_mvm_par_mac_lane.sv
// One MAC lane: registered product, exact accumulator seeded with the bias,
// and a combinational saturate/ReLU result written out on done.
module layer_mac_lane
  import layer_pkg::*;
#(
  parameter int unsigned  T    = 16,
  parameter int unsigned  N    = 10,
  parameter bit           RELU = 1'b1,
  localparam int unsigned ACCW = acc_w(T, N)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load_bias,
  input  logic                prod_en,
  input  logic                acc_en,
  input  logic                done,
  input  logic signed [T-1:0] w,
  input  logic signed [T-1:0] x,
  input  logic signed [T-1:0] bias,
  output logic signed [T-1:0] res,
  output logic                res_we
);

  logic signed [2*T-1:0]  prod;
  logic signed [ACCW-1:0] acc;

  always_ff @(posedge clk) begin
    if (reset) begin
      prod <= '0;
      acc  <= '0;
    end else begin
      if (prod_en)
        prod <= (2*T)'(w) * (2*T)'(x);
      if (load_bias)
        acc <= ACCW'(bias);
      else if (acc_en)
        acc <= acc + ACCW'(prod);
    end
  end

  always_comb begin
    res    = T'(RELU ? relu(sat_to_t(MAXW'(acc), T)) : sat_to_t(MAXW'(acc), T));
    res_we = done;
  end

endmodule

// File: rtl/layer_mvm_par.sv
// Fully-connected layer engine: load N inputs, compute M rows on P lanes,
// drain M saturated results in row order over valid/ready streams.
module layer_mvm_par
  import layer_pkg::*;
#(
  parameter int unsigned  M    = 8,
  parameter int unsigned  N    = 10,
  parameter int unsigned  P    = 1,
  parameter int unsigned  T    = 16,
  parameter bit           RELU = 1'b1,
  localparam int unsigned G    = M / P,
  localparam int unsigned WAW  = (G * N > 1) ? $clog2(G * N) : 1,
  localparam int unsigned BAW  = (G > 1) ? $clog2(G) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  layer_mvm_par_if.slave       io,
  output logic [WAW-1:0]       w_addr,
  input  logic [P*T-1:0]       w_data,
  output logic [BAW-1:0]       b_addr,
  input  logic [P*T-1:0]       b_data
);

  localparam int unsigned JW  = $clog2(N + 3);
  localparam int unsigned XIW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned OIW = (M > 1) ? $clog2(M) : 1;

  if (M % P != 0) begin : g_bad_p
    $error("layer_mvm_par: M must be a multiple of P");
  end
  if (acc_w(T, N) > MAXW) begin : g_bad_w
    $error("layer_mvm_par: accumulator exceeds helper width");
  end

  state_t              state, state_n;
  logic [JW-1:0]       cnt;
  logic [BAW-1:0]      grp;
  logic [WAW-1:0]      w_base;
  logic [OIW-1:0]      row;
  logic signed [T-1:0] xbuf [N];
  logic signed [T-1:0] obuf [M];

  logic                beat;
  logic                accept;
  logic                last_cyc;
  logic                last_grp;
  logic                load_bias;
  logic                prod_en;
  logic                acc_en;
  logic [JW-1:0]       x_idx;
  logic [JW-1:0]       w_off;
  logic signed [T-1:0] x_op;
  logic signed [T-1:0] lane_res [P];
  logic [P-1:0]        lane_we;

  always_ff @(posedge clk) begin
    if (reset) state <= LOAD;
    else       state <= state_n;
  end

  always_comb begin
    state_n     = state;
    io.s_ready  = 1'b0;
    io.m_valid  = 1'b0;
    io.data_out = '0;
    beat        = 1'b0;
    accept      = 1'b0;
    last_cyc    = 1'b0;
    last_grp    = (grp == BAW'(G - 1));
    load_bias   = 1'b0;
    prod_en     = 1'b0;
    acc_en      = 1'b0;
    unique case (state)
      LOAD: begin
        io.s_ready = !reset;
        beat       = io.s_valid && !reset;
        if (beat && cnt == JW'(N - 1))
          state_n = COMPUTE;
      end
      COMPUTE: begin
        // Per-group schedule: c=0 address, c=1 bias load + first product,
        // c=2..N+1 accumulate, c=N+2 saturate and store.
        load_bias = (cnt == JW'(1));
        prod_en   = (cnt >= JW'(1)) && (cnt <= JW'(N));
        acc_en    = (cnt >= JW'(2)) && (cnt <= JW'(N + 1));
        last_cyc  = (cnt == JW'(N + 2));
        if (last_cyc && last_grp)
          state_n = DRAIN;
      end
      DRAIN: begin
        io.m_valid  = 1'b1;
        io.data_out = obuf[row];
        accept      = io.m_ready;
        if (accept && row == OIW'(M - 1))
          state_n = LOAD;
      end
      default: state_n = LOAD;
    endcase
  end

  always_comb begin
    x_idx  = prod_en ? cnt - 1'b1 : '0;
    x_op   = prod_en ? xbuf[XIW'(x_idx)] : '0;
    w_off  = (state == COMPUTE) ? ((cnt < JW'(N)) ? cnt : JW'(N - 1)) : '0;
    w_addr = w_base + WAW'(w_off);
    b_addr = grp;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      grp    <= '0;
      w_base <= '0;
      row    <= '0;
    end else begin
      unique case (state)
        LOAD: begin
          if (beat)
            cnt <= (cnt == JW'(N - 1)) ? '0 : cnt + 1'b1;
        end
        COMPUTE: begin
          if (last_cyc) begin
            cnt    <= '0;
            grp    <= last_grp ? '0 : grp + 1'b1;
            w_base <= last_grp ? '0 : w_base + WAW'(N);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DRAIN: begin
          if (accept)
            row <= (row == OIW'(M - 1)) ? '0 : row + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (beat)
      xbuf[XIW'(cnt)] <= io.data_in;
    for (int unsigned p = 0; p < P; p++) begin
      if (lane_we[p])
        obuf[OIW'(grp * P + p)] <= lane_res[p];
    end
  end

  for (genvar p = 0; p < P; p++) begin : g_lane
    layer_mac_lane #(
      .T    (T),
      .N    (N),
      .RELU (RELU)
    ) u_lane (
      .clk       (clk),
      .reset     (reset),
      .load_bias (load_bias),
      .prod_en   (prod_en),
      .acc_en    (acc_en),
      .done      (last_cyc),
      .w         (w_data[p*T +: T]),
      .x         (x_op),
      .bias      (b_data[p*T +: T]),
      .res       (lane_res[p]),
      .res_we    (lane_we[p])
    );
  end

endmodule
